hbridge_deadtime: RTL and testbench

Sits directly downstream of the PWM generator and converts its single-bit pwm output into four gate-drive signals for one H-bridge, which is one motor coil. It steers the PWM onto the leg selected by direction and drives the opposite leg low-side on, giving synchronous slow decay. Every gate transition inside a leg is break-before-make, with a programmable dead time. All logic runs in the motor-control clock domain.

---
 rtl/hbridge_pkg.sv | 29 ++
 rtl/hbridge_deadtime_if.sv | 39 +++
 rtl/hbridge_leg.sv | 68 ++++++
 rtl/hbridge_deadtime.sv | 82 ++++++++
 tb/tb_hbridge_deadtime.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hbridge_pkg.sv
// Shared types for the H-bridge dead-time block: leg states, leg requests
// and the default dead-time counter width.
package hbridge_pkg;

   localparam int DT_BITS_DEFAULT = 8;

   typedef enum logic [1:0] {
      LEG_OFF  = 2'd0,
      LEG_HI   = 2'd1,
      LEG_LO   = 2'd2,
      LEG_DEAD = 2'd3
   } leg_state_t;

   typedef enum logic [1:0] {
      REQ_OFF = 2'd0,
      REQ_HI  = 2'd1,
      REQ_LO  = 2'd2
   } leg_req_t;

   // Requests share the state encoding, so this is a lossless mapping.
   function automatic leg_state_t req_to_state(input leg_req_t r);
      case (r)
         REQ_HI:  return LEG_HI;
         REQ_LO:  return LEG_LO;
         default: return LEG_OFF;
      endcase
   endfunction

endpackage

// File: rtl/hbridge_deadtime_if.sv
// Control and gate-drive bundle of one H-bridge.
// HBRIDGE_FAULT_EN adds fault_in, fault_clr and faulted.
interface hbridge_deadtime_if #(
   parameter int DT_BITS = hbridge_pkg::DT_BITS_DEFAULT
);
   logic               en;
   logic               pwm_in;
   logic               dir;
   logic               brake;
   logic [DT_BITS-1:0] dead_time;
   logic               a_hi;
   logic               a_lo;
   logic               b_hi;
   logic               b_lo;
   logic               busy;
`ifdef HBRIDGE_FAULT_EN
   logic               fault_in;
   logic               fault_clr;
   logic               faulted;

   modport master (
      output en, pwm_in, dir, brake, dead_time, fault_in, fault_clr,
      input  a_hi, a_lo, b_hi, b_lo, busy, faulted
   );
   modport slave (
      input  en, pwm_in, dir, brake, dead_time, fault_in, fault_clr,
      output a_hi, a_lo, b_hi, b_lo, busy, faulted
   );
`else
   modport master (
      output en, pwm_in, dir, brake, dead_time,
      input  a_hi, a_lo, b_hi, b_lo, busy
   );
   modport slave (
      input  en, pwm_in, dir, brake, dead_time,
      output a_hi, a_lo, b_hi, b_lo, busy
   );
`endif
endinterface

// File: rtl/hbridge_leg.sv
// One half-bridge leg: break-before-make state machine with a dead-time
// counter. Gates are decoded from registered state only.
module hbridge_leg
   import hbridge_pkg::*;
#(
   parameter int DT_BITS = DT_BITS_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  leg_req_t           req,
   input  logic [DT_BITS-1:0] dead_time,
   input  logic               force_off,
   output logic               hi,
   output logic               lo,
   output logic               in_dead
);

   leg_state_t         state_reg, state_next;
   logic [DT_BITS-1:0] count_reg, count_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= LEG_OFF;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

   // The counter is loaded only on entry to DEAD, so request churn while
   // dead never stretches or shortens the gap.
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      if (force_off) begin
         state_next = LEG_OFF;
         count_next = '0;
      end else begin
         case (state_reg)
            LEG_OFF: begin
               if (req != REQ_OFF)
                  state_next = req_to_state(req);
            end
            LEG_HI, LEG_LO: begin
               if (req_to_state(req) != state_reg) begin
                  state_next = LEG_DEAD;
                  count_next = dead_time;
               end
            end
            LEG_DEAD: begin
               if (count_reg != '0)
                  count_next = count_reg - DT_BITS'(1);
               else
                  state_next = req_to_state(req);
            end
            default: state_next = LEG_OFF;
         endcase
      end
   end

   always_comb begin
      hi      = (state_reg == LEG_HI);
      lo      = (state_reg == LEG_LO);
      in_dead = (state_reg == LEG_DEAD);
   end

endmodule

// File: rtl/hbridge_deadtime.sv
// H-bridge gate driver: steers PWM onto the leg chosen by dir, holds the
// other leg low-side on, and inserts dead time. Option: HBRIDGE_FAULT_EN.
module hbridge_deadtime
   import hbridge_pkg::*;
#(
   parameter int DT_BITS = DT_BITS_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   hbridge_deadtime_if.slave  bus
);

   leg_req_t leg_req     [2];
   logic     leg_hi      [2];
   logic     leg_lo      [2];
   logic     leg_in_dead [2];
   logic     force_off;
   logic     req_block;

`ifdef HBRIDGE_FAULT_EN
   logic faulted_reg, faulted_next;

   // A simultaneous fault and clear keeps the latch set.
   always_comb begin
      faulted_next = faulted_reg;
      if (bus.fault_in)
         faulted_next = 1'b1;
      else if (bus.fault_clr)
         faulted_next = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         faulted_reg <= 1'b0;
      else
         faulted_reg <= faulted_next;
   end

   assign force_off   = bus.fault_in;
   assign req_block   = faulted_reg;
   assign bus.faulted = faulted_reg;
`else
   assign force_off = 1'b0;
   assign req_block = 1'b0;
`endif

   // Leg 0 is A (switches when dir=0), leg 1 is B (switches when dir=1).
   for (genvar gi = 0; gi < 2; gi++) begin : g_leg
      localparam logic LEG_DIR = (gi == 1);

      always_comb begin
         if (!bus.en || req_block)
            leg_req[gi] = REQ_OFF;
         else if (bus.brake)
            leg_req[gi] = REQ_LO;
         else if (bus.dir == LEG_DIR)
            leg_req[gi] = bus.pwm_in ? REQ_HI : REQ_LO;
         else
            leg_req[gi] = REQ_LO;
      end

      hbridge_leg #(
         .DT_BITS (DT_BITS)
      ) u_leg (
         .clk       (clk),
         .reset     (reset),
         .req       (leg_req[gi]),
         .dead_time (bus.dead_time),
         .force_off (force_off),
         .hi        (leg_hi[gi]),
         .lo        (leg_lo[gi]),
         .in_dead   (leg_in_dead[gi])
      );
   end

   assign bus.a_hi = leg_hi[0];
   assign bus.a_lo = leg_lo[0];
   assign bus.b_hi = leg_hi[1];
   assign bus.b_lo = leg_lo[1];
   assign bus.busy = leg_in_dead[0] | leg_in_dead[1];

endmodule

// File: tb/tb_hbridge_deadtime.sv
// Scoreboard bench for hbridge_deadtime: a gap-based reference model
// predicts each cycle's gates, a negedge monitor compares.
module tb_hbridge_deadtime;
   import hbridge_pkg::*;

   localparam int DT_BITS = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   hbridge_deadtime_if #(.DT_BITS(DT_BITS)) bus();

   hbridge_deadtime #(.DT_BITS(DT_BITS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   logic [5:0] exp_q[$];

   // Model: per leg the level it drives (0 none, 1 high, 2 low) and the
   // number of both-gates-low cycles still owed before changing level.
   int lvl[2];
   int gap[2];
   bit m_faulted;

   function automatic logic [5:0] actual_vec();
      logic f;
      f = 1'b0;
`ifdef HBRIDGE_FAULT_EN
      f = bus.faulted;
`endif
      return {bus.a_hi, bus.a_lo, bus.b_hi, bus.b_lo, bus.busy, f};
   endfunction

   function automatic int want(int leg);
      if (!bus.en || m_faulted) return 0;
      if (bus.brake) return 2;
      if (leg == int'(bus.dir)) return bus.pwm_in ? 1 : 2;
      return 2;
   endfunction

   function automatic logic [5:0] expected_vec();
      logic [5:0] v;
      v[5] = (gap[0] == 0) && (lvl[0] == 1);
      v[4] = (gap[0] == 0) && (lvl[0] == 2);
      v[3] = (gap[1] == 0) && (lvl[1] == 1);
      v[2] = (gap[1] == 0) && (lvl[1] == 2);
      v[1] = (gap[0] > 0) || (gap[1] > 0);
      v[0] = m_faulted;
      return v;
   endfunction

   task automatic model_reset();
      for (int l = 0; l < 2; l++) begin
         lvl[l] = 0;
         gap[l] = 0;
      end
      m_faulted = 1'b0;
   endtask

   task automatic model_step();
      int r[2];
      bit fin;
      bit fclr;
      fin  = 1'b0;
      fclr = 1'b0;
`ifdef HBRIDGE_FAULT_EN
      fin  = bus.fault_in;
      fclr = bus.fault_clr;
`endif
      r[0] = want(0);
      r[1] = want(1);
      for (int l = 0; l < 2; l++) begin
         if (fin) begin
            lvl[l] = 0;
            gap[l] = 0;
         end else if (gap[l] > 0) begin
            gap[l] = gap[l] - 1;
            if (gap[l] == 0) lvl[l] = r[l];
         end else if (lvl[l] == 0) begin
            lvl[l] = r[l];
         end else if (r[l] != lvl[l]) begin
            gap[l] = int'(bus.dead_time) + 1;
         end
      end
      if (fin) m_faulted = 1'b1;
      else if (fclr) m_faulted = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      exp_q.push_back(expected_vec());
      @(negedge clk);
   endtask

   task automatic set_in(input logic en, input logic pwm, input logic dir,
                         input logic brake, input int dt);
      bus.en        = en;
      bus.pwm_in    = pwm;
      bus.dir       = dir;
      bus.brake     = brake;
      bus.dead_time = DT_BITS'(dt);
   endtask

   task automatic check_zero(input string name);
      logic [5:0] a;
      a = actual_vec();
      checks++;
      if (a[5:1] !== 5'b0) begin
         errors++;
         $display("FAIL %s t=%0t gates/busy=%b required=00000", name, $time, a[5:1]);
      end
   endtask

   always @(negedge clk) begin
      logic [5:0] e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = actual_vec();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs t=%0t {ahi,alo,bhi,blo,busy,flt} actual=%b required=%b",
                     $time, a, e);
         end
         checks++;
         if ((a[5] & a[4]) | (a[3] & a[2])) begin
            errors++;
            $display("FAIL shoot_through t=%0t actual=%b required=no hi&lo", $time, a);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout t=%0t actual=running required=finished", $time);
      $fatal(1, "timeout");
   end

   initial begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 0);
`ifdef HBRIDGE_FAULT_EN
      bus.fault_in  = 1'b0;
      bus.fault_clr = 1'b0;
`endif
      model_reset();
      repeat (2) @(negedge clk);
      check_zero("reset_state");
      reset = 1'b0;

      // Reset asserted mid-DEAD after a_hi was on.
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 5);
      repeat (3) step();
      bus.pwm_in = 1'b0;
      repeat (2) step();
      #2 reset = 1'b1;
      #1 check_zero("async_reset");
      @(posedge clk);
      @(negedge clk);
      check_zero("reset_held");
      model_reset();
      bus.en = 1'b0;
      reset  = 1'b0;
      repeat (4) step();

      // dead_time=3, pwm period 16.
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 3);
      for (int i = 0; i < 64; i++) begin
         bus.pwm_in = ((i % 16) < 8);
         step();
      end

      // dead_time=0, toggle every 4 cycles.
      bus.dead_time = '0;
      for (int i = 0; i < 32; i++) begin
         bus.pwm_in = ((i / 4) % 2) == 1;
         step();
      end

      // Glitch: 2-cycle pwm pulse against dead_time=5.
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5);
      repeat (10) step();
      bus.pwm_in = 1'b1;
      repeat (2) step();
      bus.pwm_in = 1'b0;
      repeat (10) step();

      // dir flip with pwm high.
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 2);
      repeat (8) step();
      bus.dir = 1'b1;
      repeat (8) step();

      // en drop, then brake.
      bus.en = 1'b0;
      repeat (6) step();
      bus.en    = 1'b1;
      bus.brake = 1'b1;
      repeat (6) step();
      bus.brake = 1'b0;

`ifdef HBRIDGE_FAULT_EN
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 2);
      repeat (6) step();
      bus.fault_in = 1'b1;
      step();
      bus.fault_in = 1'b0;
      repeat (3) step();
      bus.fault_in  = 1'b1;
      bus.fault_clr = 1'b1;
      step();
      bus.fault_in = 1'b0;
      step();
      bus.fault_clr = 1'b0;
      repeat (4) step();
`endif

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99) < 3)  bus.en = ($urandom_range(9) != 0);
         if ($urandom_range(99) < 2)  bus.brake = ($urandom_range(3) == 0);
         if ($urandom_range(99) < 2)  bus.dir = ~bus.dir;
         if ($urandom_range(99) < 20) bus.pwm_in = ~bus.pwm_in;
         if ($urandom_range(99) < 3)  bus.dead_time = DT_BITS'($urandom_range(7));
`ifdef HBRIDGE_FAULT_EN
         bus.fault_in  = ($urandom_range(199) == 0);
         bus.fault_clr = ($urandom_range(19) == 0);
`endif
         step();
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
